// File: rtl/instr_fifo_pkg.sv
// Shared defaults and mode encoding for the instruction-loading FIFO.
package instr_fifo_pkg;
  localparam int WIDTH_DEF = 10;
  localparam int DEPTH_DEF = 8;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } mode_t;
endpackage

// File: rtl/instr_fifo_if.sv
// Bus between the switch/key front panel, the processor fetch port and instr_fifo.
interface instr_fifo_if #(
  parameter int WIDTH = instr_fifo_pkg::WIDTH_DEF,
  parameter int DEPTH = instr_fifo_pkg::DEPTH_DEF
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] DIN;
  logic             WR;
  logic             START;
  logic             RD;
  logic             REPLAY;
  logic [WIDTH-1:0] DOUT;
  logic             DVALID;
  logic             FULL;
  logic             EMPTY;
  logic [CW-1:0]    COUNT;
  logic             MODE;
  logic             OVF;
  logic             UNF;

  modport master (
    output DIN, WR, START, RD, REPLAY,
    input  DOUT, DVALID, FULL, EMPTY, COUNT, MODE, OVF, UNF
  );

  modport slave (
    input  DIN, WR, START, RD, REPLAY,
    output DOUT, DVALID, FULL, EMPTY, COUNT, MODE, OVF, UNF
  );
endinterface

// File: rtl/instr_fifo_edge_det.sv
// One-bit rising-edge detector: evt is high for the cycle where d=1 and its registered copy is 0.
module edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic evt
);
  logic q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= 1'b0;
    else        q <= d;
  end

  assign evt = d & ~q;
endmodule

// File: rtl/instr_fifo.sv
// Instruction FIFO: loaded from switches in LOAD mode, drained by processor fetches in RUN mode.
// Optional macro INSTR_FIFO_REPLAY_EN adds program rewind on a REPLAY event.
module instr_fifo
  import instr_fifo_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input logic          CLK50MHz,
  input logic          RSTb,
  instr_fifo_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr, rd_ptr_inc;
  logic [CW-1:0]    count, count_next;
  logic [WIDTH-1:0] dout;
  logic             ovf, unf;
  mode_t            state, state_next;

  logic wr_evt, start_evt, replay_evt;
  logic full, empty, dvalid;
  logic push, pop, ovf_set, unf_set, enter_run, replay;

  edge_det u_wr     (.clk(CLK50MHz), .rst_n(RSTb), .d(bus.WR),     .evt(wr_evt));
  edge_det u_start  (.clk(CLK50MHz), .rst_n(RSTb), .d(bus.START),  .evt(start_evt));
  edge_det u_replay (.clk(CLK50MHz), .rst_n(RSTb), .d(bus.REPLAY), .evt(replay_evt));

`ifdef INSTR_FIFO_REPLAY_EN
  logic [PW-1:0] rd_save;
  logic [CW-1:0] cnt_save;
  assign replay = replay_evt && (state == RUN);
`else
  logic unused_replay;
  assign unused_replay = replay_evt;
  assign replay        = 1'b0;
`endif

  assign full       = (count == CW'(DEPTH));
  assign empty      = (count == '0);
  assign dvalid     = !empty;
  assign rd_ptr_inc = rd_ptr + 1'b1;

  always_comb begin
    push       = wr_evt && (state == LOAD) && !full;
    ovf_set    = wr_evt && (state == LOAD) && full;
    pop        = bus.RD && (state == RUN) && dvalid && !replay;
    unf_set    = bus.RD && ((state == LOAD) || !dvalid);
    count_next = count + CW'(push) - CW'(pop);
  end

  always_ff @(posedge CLK50MHz or negedge RSTb) begin
    if (!RSTb) state <= LOAD;
    else       state <= state_next;
  end

  // The LOAD exit test uses count_next so a push coinciding with START counts.
  always_comb begin
    state_next = state;
    unique case (state)
      LOAD: if (start_evt && (count_next != '0)) state_next = RUN;
      RUN: begin
        if (start_evt) state_next = LOAD;
`ifndef INSTR_FIFO_REPLAY_EN
        else if (pop && (count_next == '0)) state_next = LOAD;
`endif
      end
      default: state_next = LOAD;
    endcase
  end

  always_comb begin
    enter_run  = (state == LOAD) && (state_next == RUN);
    bus.MODE   = (state == RUN);
    bus.DOUT   = dout;
    bus.DVALID = dvalid;
    bus.FULL   = full;
    bus.EMPTY  = empty;
    bus.COUNT  = count;
    bus.OVF    = ovf;
    bus.UNF    = unf;
  end

  always_ff @(posedge CLK50MHz) begin
    if (push) mem[wr_ptr] <= bus.DIN;
  end

  always_ff @(posedge CLK50MHz or negedge RSTb) begin
    if (!RSTb) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dout   <= '0;
      ovf    <= 1'b0;
      unf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
`ifdef INSTR_FIFO_REPLAY_EN
      if (replay) begin
        rd_ptr <= rd_save;
        count  <= cnt_save;
        dout   <= mem[rd_save];
      end else
`endif
      begin
        count <= count_next;
        if (pop) rd_ptr <= rd_ptr_inc;
        // Head register bypasses storage when the first word lands in an empty queue.
        if (push && empty) dout <= bus.DIN;
        else if (pop)      dout <= mem[rd_ptr_inc];
      end
      if (enter_run) begin
        ovf <= 1'b0;
        unf <= 1'b0;
      end else begin
        if (ovf_set) ovf <= 1'b1;
        if (unf_set) unf <= 1'b1;
      end
    end
  end

`ifdef INSTR_FIFO_REPLAY_EN
  always_ff @(posedge CLK50MHz or negedge RSTb) begin
    if (!RSTb) begin
      rd_save  <= '0;
      cnt_save <= '0;
    end else if (enter_run) begin
      rd_save  <= rd_ptr;
      cnt_save <= count_next;
    end
  end
`endif
endmodule

// File: tb/tb_instr_fifo.sv
// Directed, table-driven bench for instr_fifo (DEPTH=8, WIDTH=10).
module tb_instr_fifo;
  localparam int W = 10;
  localparam int D = 8;

  logic clk = 1'b0;
  logic rstb = 1'b0;
  int   passed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  instr_fifo_if #(.WIDTH(W), .DEPTH(D)) bus ();

  instr_fifo #(.WIDTH(W), .DEPTH(D)) dut (
    .CLK50MHz(clk),
    .RSTb    (rstb),
    .bus     (bus)
  );

  typedef struct {
    logic         wr;
    logic         st;
    logic         rd;
    logic [W-1:0] din;
    int           cnt;
    logic [W-1:0] dout;
    logic         chk_dout;
    logic         mode;
    logic         ovf;
    logic         unf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic wr, logic st, logic rd, logic [W-1:0] din, int cnt,
                              logic [W-1:0] dout, logic chk_dout, logic mode, logic ovf, logic unf);
    vec_t v;
    v.wr = wr; v.st = st; v.rd = rd; v.din = din; v.cnt = cnt;
    v.dout = dout; v.chk_dout = chk_dout; v.mode = mode; v.ovf = ovf; v.unf = unf;
    return v;
  endfunction

  task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s [step %0d]: got %0h, expected %0h", name, idx, act, exp);
  endtask

  task automatic check_state(int idx, int cnt, logic [W-1:0] dout, logic chk_dout,
                             logic mode, logic ovf, logic unf);
    chk("COUNT",  idx, 32'(bus.COUNT), 32'(cnt));
    chk("FULL",   idx, 32'(bus.FULL),  32'(cnt == D));
    chk("EMPTY",  idx, 32'(bus.EMPTY), 32'(cnt == 0));
    chk("DVALID", idx, 32'(bus.DVALID), 32'(cnt > 0));
    chk("MODE",   idx, 32'(bus.MODE),  32'(mode));
    chk("OVF",    idx, 32'(bus.OVF),   32'(ovf));
    chk("UNF",    idx, 32'(bus.UNF),   32'(unf));
    if (chk_dout) chk("DOUT", idx, 32'(bus.DOUT), 32'(dout));
  endtask

  // One event: inputs high for one rising edge, checked, then one idle edge.
  task automatic apply(logic wr, logic st, logic rd, logic rp, logic [W-1:0] din);
    @(negedge clk);
    bus.WR = wr; bus.START = st; bus.RD = rd; bus.REPLAY = rp; bus.DIN = din;
    @(negedge clk);
  endtask

  task automatic idle();
    bus.WR = 1'b0; bus.START = 1'b0; bus.RD = 1'b0; bus.REPLAY = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rstb = 1'b0;
    repeat (2) @(negedge clk);
    rstb = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    bus.WR = 1'b0; bus.START = 1'b0; bus.RD = 1'b0; bus.REPLAY = 1'b0; bus.DIN = '0;
    do_reset();
    check_state(-1, 0, 10'h000, 1'b1, 1'b0, 1'b0, 1'b0);

`ifndef INSTR_FIFO_REPLAY_EN
    //                 wr st rd din      cnt dout     chk mode ovf unf
    vecs.push_back(mk(0, 0, 1, 10'h000, 0, 10'h000, 1, 0, 0, 1)); // RD while empty
    vecs.push_back(mk(0, 1, 0, 10'h000, 0, 10'h000, 1, 0, 0, 1)); // START with nothing loaded
    vecs.push_back(mk(1, 0, 0, 10'h001, 1, 10'h001, 1, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 10'h0A5, 2, 10'h001, 1, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 10'h3FF, 3, 10'h001, 1, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 10'h000, 3, 10'h001, 1, 1, 0, 0)); // RUN clears UNF
    vecs.push_back(mk(1, 0, 0, 10'h155, 3, 10'h001, 1, 1, 0, 0)); // WR ignored in RUN
    vecs.push_back(mk(0, 0, 1, 10'h000, 2, 10'h0A5, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 10'h000, 1, 10'h3FF, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 10'h000, 0, 10'h000, 0, 0, 0, 0)); // empties -> LOAD
    vecs.push_back(mk(0, 0, 1, 10'h000, 0, 10'h000, 0, 0, 0, 1));
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(1, 0, 0, 10'(10'h010 + i), i + 1, 10'h010, 1, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 10'h3AA, 8, 10'h010, 1, 0, 1, 1)); // overflow
    vecs.push_back(mk(0, 1, 0, 10'h000, 8, 10'h010, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 10'h000, 7, 10'h011, 1, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 10'h000, 7, 10'h011, 1, 0, 0, 0)); // START leaves RUN
    vecs.push_back(mk(1, 0, 0, 10'h2C3, 8, 10'h011, 1, 0, 0, 0)); // write pointer wraps
    vecs.push_back(mk(0, 1, 0, 10'h000, 8, 10'h011, 1, 1, 0, 0));
    for (int k = 0; k < 6; k++)
      vecs.push_back(mk(0, 0, 1, 10'h000, 7 - k, 10'(10'h012 + k), 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 10'h000, 1, 10'h2C3, 1, 1, 0, 0)); // read pointer wraps
    vecs.push_back(mk(0, 0, 1, 10'h000, 0, 10'h000, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 10'h07F, 1, 10'h07F, 1, 1, 0, 0)); // push then START
    vecs.push_back(mk(0, 0, 1, 10'h000, 0, 10'h000, 0, 0, 0, 0));

    foreach (vecs[i]) begin
      apply(vecs[i].wr, vecs[i].st, vecs[i].rd, 1'b0, vecs[i].din);
      check_state(i, vecs[i].cnt, vecs[i].dout, vecs[i].chk_dout,
                  vecs[i].mode, vecs[i].ovf, vecs[i].unf);
      idle();
    end
`else
    apply(1, 0, 0, 0, 10'h123); idle();
    apply(1, 0, 0, 0, 10'h045); idle();
    apply(0, 1, 0, 0, 10'h000);
    check_state(100, 2, 10'h123, 1'b1, 1'b1, 1'b0, 1'b0);
    idle();
    apply(0, 0, 1, 0, 10'h000);
    check_state(101, 1, 10'h045, 1'b1, 1'b1, 1'b0, 1'b0);
    idle();
    apply(0, 0, 1, 0, 10'h000);
    check_state(102, 0, 10'h000, 1'b0, 1'b1, 1'b0, 1'b0); // stays in RUN when empty
    idle();
    apply(0, 0, 0, 1, 10'h000);
    check_state(103, 2, 10'h123, 1'b1, 1'b1, 1'b0, 1'b0);
    idle();
    apply(0, 0, 1, 0, 10'h000);
    check_state(104, 1, 10'h045, 1'b1, 1'b1, 1'b0, 1'b0);
    idle();
    apply(0, 1, 0, 0, 10'h000);
    check_state(105, 1, 10'h045, 1'b1, 1'b0, 1'b0, 1'b0);
    idle();
    do_reset();
`endif

    // Asynchronous reset in the middle of RUN
    apply(1, 0, 0, 0, 10'h111); idle();
    apply(1, 0, 0, 0, 10'h222); idle();
    apply(0, 1, 0, 0, 10'h000);
    check_state(200, 2, 10'h111, 1'b1, 1'b1, 1'b0, 1'b0);
    idle();
    #2 rstb = 1'b0;
    #1 check_state(201, 0, 10'h000, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rstb = 1'b1;
    @(negedge clk);
    check_state(202, 0, 10'h000, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/instr_fifo.md
INSTR_FIFO -- requirements
Module: instr_fifo

Interface
REQ-001 Parameter DEPTH, default 8: number of 10-bit entries; a power of two, 2..16.
REQ-002 Parameter WIDTH, default 10: word width, equal to the processor data bus width.
REQ-003 CLK50MHz  in  1  the only clock; all state changes on its rising edge.
REQ-004 RSTb  in  1  asynchronous, active-low reset.
REQ-005 DIN  in  WIDTH  word to enqueue, taken from the switch bank.
REQ-006 WR  in  1  debounced load key, level; its rising edge requests a push.
REQ-007 START  in  1  debounced key, level; its rising edge requests a mode change.
REQ-008 RD  in  1  single-cycle pop strobe from the processor's external-data fetch.
REQ-009 REPLAY  in  1  level; its rising edge rewinds the program (only with the REQ-031 macro).
REQ-010 DOUT  out  WIDTH  head word, which drives the processor external data input.
REQ-011 DVALID  out  1  DOUT holds a valid head word.
REQ-012 FULL / EMPTY  out  1 each  occupancy flags.
REQ-013 COUNT  out  clog2(DEPTH)+1  number of stored entries.
REQ-014 MODE  out  1  0 = LOAD, 1 = RUN.
REQ-015 OVF / UNF  out  1 each  sticky overflow and underflow flags.

Function
REQ-016 WR, START and REPLAY each SHALL pass through a rising-edge detector, giving a one-cycle event in the cycle where the input is 1 and its registered copy is 0.
REQ-017 The FSM SHALL have two states, LOAD and RUN; reset state is LOAD.
REQ-018 LOAD -> RUN on a START event when COUNT>0; a START event with COUNT=0 SHALL be ignored.
REQ-019 RUN -> LOAD on a START event, or in the cycle after the pop that empties the queue.
REQ-020 In LOAD, a WR event with FULL=0 SHALL write DIN at the write pointer and increment the write pointer (mod DEPTH) and COUNT.
REQ-021 In LOAD, a WR event with FULL=1 SHALL discard DIN, leave all state unchanged and set OVF.
REQ-022 In RUN, WR events SHALL be ignored and SHALL NOT set OVF.
REQ-023 In RUN, RD with DVALID=1 SHALL advance the read pointer (mod DEPTH) and decrement COUNT.
REQ-024 RD with DVALID=0, or RD in LOAD, SHALL set UNF and change nothing else.
REQ-025 DOUT SHALL be registered and equal mem[rd_ptr] one cycle after any write to an empty queue or any pop; DVALID = (COUNT>0).
REQ-026 FULL = (COUNT=DEPTH); EMPTY = (COUNT=0); both are combinational from COUNT.
REQ-027 OVF and UNF SHALL clear only on a LOAD -> RUN transition or on reset.
REQ-028 Simultaneous WR and START events in LOAD: the push SHALL occur first, and the transition SHALL use the post-push COUNT.

Reset
REQ-029 RSTb=0 SHALL asynchronously clear pointers, COUNT, OVF, UNF, DOUT (to 0) and edge-detector registers, and set MODE=LOAD; storage contents are don't-care.
REQ-030 A reset asserted mid-RUN SHALL abandon the program; after release EMPTY=1 and DVALID=0.

Configuration
REQ-031 Macro INSTR_FIFO_REPLAY_EN: when defined, the read pointer and COUNT are captured on each LOAD -> RUN transition, and a REPLAY event in RUN restores them, with DOUT valid on the next cycle.
REQ-032 When INSTR_FIFO_REPLAY_EN is defined, the RUN -> LOAD transition on empty SHALL NOT occur; RUN exits only on START.
REQ-033 When INSTR_FIFO_REPLAY_EN is not defined, REPLAY is ignored, no capture registers exist, and REQ-019 applies unchanged.

Structure
REQ-034 Package instr_fifo_pkg SHALL hold the WIDTH and DEPTH defaults and the mode_t enum {LOAD, RUN}.
REQ-035 Sub-module edge_det (1-bit rising-edge detector, same clock and reset) SHALL be instantiated once each for WR, START and REPLAY.

Verification
REQ-036 Reset, then three WR events with DIN=0x001, 0x0A5, 0x3FF -> COUNT=3, DOUT=0x001, DVALID=1, MODE=0.
REQ-037 START, then three RD pulses -> DOUT steps to 0x0A5, then 0x3FF, then DVALID=0; MODE returns to 0 one cycle after the third pop.
REQ-038 Nine WR events with DEPTH=8 -> FULL=1 after the eighth, OVF=1 after the ninth, and COUNT stays 8.
REQ-039 RD pulse while EMPTY -> UNF=1, COUNT=0; a later valid START -> UNF=0.
REQ-040 With INSTR_FIFO_REPLAY_EN: load 2 words, START, pop 2, REPLAY -> COUNT=2, DOUT = first word, MODE stays 1.
REQ-041 RSTb pulled low mid-RUN with COUNT=2 -> all outputs return to reset values immediately, without waiting for a clock edge.
